// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/redirect bundle between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [1:0]  ctrl_state;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, ctrl_state
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, ctrl_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, exception/ERET redirect sequencing and stall watchdog
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int          MAX_STALL  = 1024,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PEND    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [5:0]       STALL_MEM = 6'b011111;
  localparam logic [5:0]       STALL_EX  = 6'b001111;
  localparam logic [5:0]       STALL_ID  = 6'b000111;
  localparam logic [31:0]      ERET_CODE = 32'h0000000e;
  localparam logic [CNT_W-1:0] TRIP_CNT  = CNT_W'(MAX_STALL - 1);

  state_t           state;
  state_t           next_state;
  logic [31:0]      pend_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  logic [5:0]  prio_stall;
  logic [31:0] target;
  logic        exc_valid;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        latch_pend;

  assign exc_valid = |bus.excepttype_i;
  assign target    = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;

  always_comb begin
    prio_stall = 6'b000000;
    if (bus.stallreq_from_mem)     prio_stall = STALL_MEM;
    else if (bus.stallreq_from_ex) prio_stall = STALL_EX;
    else if (bus.stallreq_from_id) prio_stall = STALL_ID;
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  always_comb begin
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    new_pc_c   = 32'h0;
    latch_pend = 1'b0;
    next_state = RUN;
    if (rst) begin
      case (state)
        RUN: begin
          if (exc_valid && !bus.stallreq_from_mem) begin
            flush_c    = 1'b1;
            new_pc_c   = target;
            next_state = RECOVER;
          end else if (exc_valid) begin
            stall_c    = STALL_MEM;
            latch_pend = 1'b1;
            next_state = PEND;
          end else begin
            stall_c    = prio_stall;
          end
        end
        PEND: begin
          if (bus.stallreq_from_mem) begin
            stall_c    = STALL_MEM;
            next_state = PEND;
          end else begin
            flush_c    = 1'b1;
            new_pc_c   = pend_pc;
            next_state = RECOVER;
          end
        end
        // RECOVER ignores excepttype_i so a stale code cannot redirect twice.
        RECOVER: stall_c = prio_stall;
        default: stall_c = prio_stall;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_pc   <= 32'h0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= next_state;
      if (latch_pend) pend_pc <= target;
      if (|stall_c) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt == TRIP_CNT) timeout_q <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_timeout = timeout_q;
  assign bus.ctrl_state    = state;

endmodule
